// File: rtl/scan_sequencer_pkg.sv
// Shared constants for the scan sequencer: FSM states, compare results, register map, STATUS layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scan_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scanState_t;

    // Result of comparing QUERY against one subject entry, seen from the query side.
    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_GT = 2'd1,
        CMP_LT = 2'd2
    } cmpRes_t;

    // CTRL register bit positions
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_ABORT_BIT = 1;
    localparam int CTRL_CLEAR_BIT = 2;

    // Register offsets from the block base address
    localparam logic [31:0] OFF_CTRL   = 32'h00;
    localparam logic [31:0] OFF_QUERY  = 32'h10;
    localparam logic [31:0] OFF_SUBJ   = 32'h20;
    localparam logic [31:0] OFF_STATUS = 32'h30;

    // STATUS field positions
    localparam int ST_STATE_LSB = 0;
    localparam int ST_OVF_BIT   = 2;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_HIT_LSB   = 16;
    localparam int ST_GT_LSB    = 24;
    localparam int ST_LT_LSB    = 32;
    localparam int ST_FIRST_LSB = 40;

    // Width of the hit/gt/lt counters and of first_hit
    localparam int RES_W = 8;

    // True when a bus address hits the register at base+offset.
    function automatic logic addrHit(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [31:0] off);
        return addr == (base + off);
    endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// PicoBus register-access bundle between a bus master and the scan sequencer.
// Latency: read data returns one cycle after the read strobe.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
interface scan_sequencer_if;
    logic [31:0]  PicoAddr;
    logic [127:0] PicoDataIn;
    logic         PicoRd;
    logic         PicoWr;
    logic [127:0] PicoDataOut;

    modport master (
        output PicoAddr,
        output PicoDataIn,
        output PicoRd,
        output PicoWr,
        input  PicoDataOut
    );

    modport slave (
        input  PicoAddr,
        input  PicoDataIn,
        input  PicoRd,
        input  PicoWr,
        output PicoDataOut
    );
endinterface

// File: rtl/scan_cmp_unit.sv
// Registered equal/greater/less decode of query versus one subject symbol, index carried alongside.
// Latency: 1 cycle from inVld to outVld.
// Backpressure: none; a new compare may be issued every cycle.
module scan_cmp_unit
    import scan_sequencer_pkg::*;
#(
    parameter int SYM_W = 5,
    parameter int IDX_W = 5
) (
    input  logic             PicoClk,
    input  logic             rst,
    input  logic             inVld,
    input  logic [SYM_W-1:0] query,
    input  logic [SYM_W-1:0] subject,
    input  logic [IDX_W-1:0] inIdx,
    output logic             outVld,
    output cmpRes_t          outRes,
    output logic [IDX_W-1:0] outIdx
);

    // Capture one compare result per issued entry; the index travels with it for first-hit tracking.
    always_ff @(posedge PicoClk or negedge rst) begin
        if (!rst) begin
            outVld <= 1'b0;
            outRes <= CMP_EQ;
            outIdx <= '0;
        end else begin
            outVld <= inVld;
            if (inVld) begin
                outIdx <= inIdx;
                if (query == subject)
                    outRes <= CMP_EQ;
                else if (query > subject)
                    outRes <= CMP_GT;
                else
                    outRes <= CMP_LT;
            end
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Register-mapped scan engine: compares QUERY against every buffered subject symbol and tallies results.
// Latency: start-write to DONE in count+2 cycles (1 cycle for an empty buffer); reads return after 1 cycle.
// Backpressure: none; pushes that cannot be stored are dropped and flagged in the sticky ovf bit.
module scan_sequencer
    import scan_sequencer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h100,
    parameter int          DEPTH     = 16,
    parameter int          SYM_W     = 5
) (
    input  logic            PicoClk,
    input  logic            rst,
    scan_sequencer_if.slave bus
);

    localparam int               IDX_W      = $clog2(DEPTH);
    localparam int               CNT_W      = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    scanState_t       state;
    scanState_t       stateNext;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] scanIdx;
    logic [SYM_W-1:0] query;
    logic [RES_W-1:0] hitCnt;
    logic [RES_W-1:0] gtCnt;
    logic [RES_W-1:0] ltCnt;
    logic [RES_W-1:0] firstHit;
    logic             ovf;
    logic [SYM_W-1:0] subjBuf [DEPTH];

    logic             cmpVld;
    cmpRes_t          cmpRes;
    logic [CNT_W-1:0] cmpIdx;

    logic [127:0]     statusWord;
    logic [127:0]     rdNext;

    // Only the low symbol/CTRL bits of the write data carry meaning.
    logic             unusedBits;
    assign unusedBits = ^bus.PicoDataIn[127:SYM_W];

    // Bus write decode
    logic ctrlWr, queryWr, subjWr;
    assign ctrlWr  = bus.PicoWr && addrHit(bus.PicoAddr, BASE_ADDR, OFF_CTRL);
    assign queryWr = bus.PicoWr && addrHit(bus.PicoAddr, BASE_ADDR, OFF_QUERY);
    assign subjWr  = bus.PicoWr && addrHit(bus.PicoAddr, BASE_ADDR, OFF_SUBJ);

    // CTRL bits resolved with abort over clear over start; each is only taken in a state that accepts it.
    logic abortBit, clearBit, startBit;
    logic abortTake, clearTake, startTake;
    assign abortBit  = ctrlWr && bus.PicoDataIn[CTRL_ABORT_BIT];
    assign clearBit  = ctrlWr && bus.PicoDataIn[CTRL_CLEAR_BIT];
    assign startBit  = ctrlWr && bus.PicoDataIn[CTRL_START_BIT];
    assign abortTake = abortBit && (state == SCAN);
    assign clearTake = !abortBit && clearBit && (state != SCAN);
    assign startTake = !abortBit && !clearBit && startBit && (state != SCAN);

    logic pushTake, pushDrop;
    assign pushTake = subjWr && (count != FULL_COUNT) && (state != SCAN);
    assign pushDrop = subjWr && !pushTake;

    // Issue one entry per cycle until all are issued; results retire one cycle later.
    // An abort kills both the issue and the retire of that cycle so nothing stale survives.
    logic issueVld, retireVld, lastRetire;
    assign issueVld   = (state == SCAN) && !abortTake && (scanIdx < count);
    assign retireVld  = (state == SCAN) && !abortTake && cmpVld;
    assign lastRetire = retireVld && (scanIdx == count);

    scan_cmp_unit #(
        .SYM_W (SYM_W),
        .IDX_W (CNT_W)
    ) u_cmp (
        .PicoClk (PicoClk),
        .rst     (rst),
        .inVld   (issueVld),
        .query   (query),
        .subject (subjBuf[scanIdx[IDX_W-1:0]]),
        .inIdx   (scanIdx),
        .outVld  (cmpVld),
        .outRes  (cmpRes),
        .outIdx  (cmpIdx)
    );

    // FSM state register
    always_ff @(posedge PicoClk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // FSM next state; an empty buffer skips the scan entirely
    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: begin
                if (clearTake)
                    stateNext = IDLE;
                else if (startTake)
                    stateNext = (count == '0) ? DONE : SCAN;
            end
            SCAN: begin
                if (abortTake)
                    stateNext = IDLE;
                else if (lastRetire)
                    stateNext = DONE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Subject buffer storage; contents are irrelevant until pushed, so no reset
    always_ff @(posedge PicoClk) begin
        if (pushTake)
            subjBuf[count[IDX_W-1:0]] <= bus.PicoDataIn[SYM_W-1:0];
    end

    // Fill level and sticky overflow
    always_ff @(posedge PicoClk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clearTake) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (pushTake) begin
            count <= count + 1'b1;
        end else if (pushDrop) begin
            ovf   <= 1'b1;
        end
    end

    // QUERY is frozen while a scan is using it
    always_ff @(posedge PicoClk or negedge rst) begin
        if (!rst)
            query <= '0;
        else if (queryWr && (state != SCAN))
            query <= bus.PicoDataIn[SYM_W-1:0];
    end

    // Scan index and result tallies; first hit is recorded while the hit count is still zero
    always_ff @(posedge PicoClk or negedge rst) begin
        if (!rst) begin
            scanIdx  <= '0;
            hitCnt   <= '0;
            gtCnt    <= '0;
            ltCnt    <= '0;
            firstHit <= '1;
        end else if (startTake) begin
            scanIdx  <= '0;
            hitCnt   <= '0;
            gtCnt    <= '0;
            ltCnt    <= '0;
            firstHit <= '1;
        end else begin
            if (issueVld)
                scanIdx <= scanIdx + 1'b1;
            if (retireVld) begin
                case (cmpRes)
                    CMP_EQ: begin
                        hitCnt <= hitCnt + 8'd1;
                        if (hitCnt == '0)
                            firstHit <= RES_W'(cmpIdx);
                    end
                    CMP_GT:  gtCnt <= gtCnt + 8'd1;
                    default: ltCnt <= ltCnt + 8'd1;
                endcase
            end
        end
    end

    // STATUS word assembly
    always_comb begin
        statusWord                            = '0;
        statusWord[ST_STATE_LSB +: 2]         = state;
        statusWord[ST_OVF_BIT]                = ovf;
        statusWord[ST_COUNT_LSB +: CNT_W]     = count;
        statusWord[ST_HIT_LSB +: RES_W]       = hitCnt;
        statusWord[ST_GT_LSB +: RES_W]        = gtCnt;
        statusWord[ST_LT_LSB +: RES_W]        = ltCnt;
        statusWord[ST_FIRST_LSB +: RES_W]     = firstHit;
    end

    // Read mux; anything not readable returns zero
    always_comb begin
        rdNext = '0;
        if (bus.PicoRd) begin
            if (addrHit(bus.PicoAddr, BASE_ADDR, OFF_QUERY))
                rdNext = 128'(query);
            else if (addrHit(bus.PicoAddr, BASE_ADDR, OFF_STATUS))
                rdNext = statusWord;
        end
    end

    // Registered read data
    always_ff @(posedge PicoClk or negedge rst) begin
        if (!rst)
            bus.PicoDataOut <= '0;
        else
            bus.PicoDataOut <= rdNext;
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer with a cycle-timed behavioural model of the register file.
// Latency: checks read data one cycle after every read strobe, and zero on all other cycles.
// Backpressure: none; the bench drives one bus operation per cycle.
module tb_scan_sequencer;

    localparam logic [31:0] BASE     = 32'h100;
    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_QUERY  = BASE + 32'h10;
    localparam logic [31:0] A_SUBJ   = BASE + 32'h20;
    localparam logic [31:0] A_STATUS = BASE + 32'h30;
    localparam logic [31:0] A_UNMAP  = BASE + 32'h40;

    logic PicoClk = 1'b0;
    logic rst     = 1'b0;
    always #5 PicoClk = ~PicoClk;

    scan_sequencer_if bus();

    scan_sequencer #(
        .BASE_ADDR (BASE),
        .DEPTH     (16),
        .SYM_W     (5)
    ) dut (
        .PicoClk (PicoClk),
        .rst     (rst),
        .bus     (bus)
    );

    int cyc = 0;
    always @(posedge PicoClk) cyc <= cyc + 1;

    int checkCnt = 0;
    int passCnt  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checkCnt++;
        if (act === exp)
            passCnt++;
        else
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Timeline view: a scan started in cycle t0 over n entries is SCAN from t0+1 and DONE
    // from t0+n+2; entry j's result is visible from cycle t0+j+3 onward.
    int mBuf [16];
    int scanBuf [16];
    int mCount, mQuery, mOvf;
    int scanT0, scanN, scanQ, abortAt, clearAt;

    task automatic modelReset();
        mCount  = 0;
        mQuery  = 0;
        mOvf    = 0;
        scanT0  = -1;
        scanN   = 0;
        scanQ   = 0;
        abortAt = -1;
        clearAt = -1;
    endtask

    function automatic int modelState(input int c);
        int rel;
        if (scanT0 < 0) return 0;
        rel = c - scanT0;
        if (abortAt >= 0 && rel > abortAt) return 0;
        if (clearAt >= 0 && c > clearAt) return 0;
        if (scanN == 0) return 2;
        if (rel < scanN + 2) return 1;
        return 2;
    endfunction

    function automatic logic [127:0] modelStatus(input int c);
        logic [127:0] s;
        int rel, lim, k, h, g, l, fh;
        h = 0; g = 0; l = 0; fh = 255;
        if (scanT0 >= 0) begin
            rel = c - scanT0;
            lim = rel;
            if (abortAt >= 0 && abortAt < lim) lim = abortAt;
            k = lim - 2;
            if (k < 0) k = 0;
            if (k > scanN) k = scanN;
            for (int j = 0; j < k; j++) begin
                if (scanBuf[j] == scanQ) begin
                    if (h == 0) fh = j;
                    h++;
                end else if (scanQ > scanBuf[j]) g++;
                else l++;
            end
        end
        s        = '0;
        s[1:0]   = 2'(modelState(c));
        s[2]     = (mOvf != 0);
        s[12:8]  = 5'(mCount);
        s[23:16] = 8'(h);
        s[31:24] = 8'(g);
        s[39:32] = 8'(l);
        s[47:40] = 8'(fh);
        return s;
    endfunction

    function automatic logic [127:0] modelRead(input logic [31:0] a, input int c);
        if (a == A_QUERY)  return 128'(mQuery);
        if (a == A_STATUS) return modelStatus(c);
        return '0;
    endfunction

    task automatic modelWrite(input logic [31:0] a, input logic [127:0] d, input int c);
        int s;
        s = modelState(c);
        if (a == A_CTRL) begin
            if (d[1]) begin
                if (s == 1) abortAt = c - scanT0;
            end else if (d[2]) begin
                if (s != 1) begin
                    mCount = 0;
                    mOvf   = 0;
                    if (scanT0 >= 0) clearAt = c;
                end
            end else if (d[0]) begin
                if (s != 1) begin
                    scanT0  = c;
                    scanN   = mCount;
                    scanQ   = mQuery;
                    abortAt = -1;
                    clearAt = -1;
                    for (int j = 0; j < 16; j++) scanBuf[j] = mBuf[j];
                end
            end
        end else if (a == A_QUERY) begin
            if (s != 1) mQuery = int'(d[4:0]);
        end else if (a == A_SUBJ) begin
            if (s == 1 || mCount == 16) mOvf = 1;
            else begin
                mBuf[mCount] = int'(d[4:0]);
                mCount++;
            end
        end
    endtask

    // ---------------- expected read-data stream ----------------
    typedef struct {
        int           due;
        logic [127:0] val;
    } expRd_t;
    expRd_t expQ [$];

    // Every cycle: read data must match the model one cycle after a read, and be zero otherwise.
    always @(negedge PicoClk) begin
        logic [127:0] want;
        want = '0;
        if (expQ.size() > 0 && expQ[0].due == cyc) begin
            want = expQ[0].val;
            void'(expQ.pop_front());
        end
        check("rdata_vs_model", bus.PicoDataOut, want);
    end

    // ---------------- bus driver ----------------
    task automatic busIdle();
        @(negedge PicoClk);
        bus.PicoRd = 1'b0;
        bus.PicoWr = 1'b0;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [127:0] d);
        @(negedge PicoClk);
        bus.PicoAddr   = a;
        bus.PicoDataIn = d;
        bus.PicoWr     = 1'b1;
        bus.PicoRd     = 1'b0;
        modelWrite(a, d, cyc);
    endtask

    task automatic busRead(input logic [31:0] a);
        expRd_t e;
        @(negedge PicoClk);
        bus.PicoAddr = a;
        bus.PicoRd   = 1'b1;
        bus.PicoWr   = 1'b0;
        e.due = cyc + 1;
        e.val = modelRead(a, cyc);
        expQ.push_back(e);
    endtask

    // Read and also pin the returned word against a hand-computed value.
    task automatic readLit(input string name, input logic [31:0] a, input logic [127:0] lit);
        busRead(a);
        @(posedge PicoClk);
        #1;
        check(name, bus.PicoDataOut, lit);
    endtask

    task automatic pushSym(input int v);
        busWrite(A_SUBJ, 128'(v));
    endtask

    task automatic idleN(input int n);
        for (int i = 0; i < n; i++) busIdle();
    endtask

    task automatic applyReset();
        busIdle();
        @(negedge PicoClk);
        rst = 1'b0;
        modelReset();
        expQ.delete();
        idleN(2);
        @(negedge PicoClk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 time units, want finish");
        $fatal(1);
    end

    initial begin
        bus.PicoAddr   = '0;
        bus.PicoDataIn = '0;
        bus.PicoRd     = 1'b0;
        bus.PicoWr     = 1'b0;
        modelReset();
        repeat (3) @(negedge PicoClk);
        rst = 1'b1;

        // Reset values
        readLit("reset_status", A_STATUS, 128'hFF00_0000_0000);
        readLit("reset_query", A_QUERY, 128'h0);

        // Basic scan: 3,7,3,9 against 3
        pushSym(3); pushSym(7); pushSym(3); pushSym(9);
        busWrite(A_QUERY, 128'd3);
        readLit("query_readback", A_QUERY, 128'h3);
        busWrite(A_CTRL, 128'h1);
        idleN(4);
        readLit("scan_mid_c5", A_STATUS, 128'h0001_0002_0401);
        readLit("scan_done_c6", A_STATUS, 128'h0002_0002_0402);
        readLit("done_holds", A_STATUS, 128'h0002_0002_0402);

        // Rescan with a QUERY write during SCAN that must be ignored
        busWrite(A_CTRL, 128'h1);
        busWrite(A_QUERY, 128'd9);
        idleN(4);
        readLit("rescan_done", A_STATUS, 128'h0002_0002_0402);
        readLit("query_frozen", A_QUERY, 128'h3);

        // New query outside SCAN
        busWrite(A_QUERY, 128'd7);
        busWrite(A_CTRL, 128'h1);
        idleN(5);
        readLit("q7_done", A_STATUS, 128'h0101_0201_0402);

        // Start during SCAN is ignored
        busWrite(A_CTRL, 128'h1);
        busWrite(A_CTRL, 128'h1);
        idleN(4);
        readLit("restart_ignored", A_STATUS, 128'h0101_0201_0402);

        // Clear from DONE: back to IDLE, count zero, tallies kept
        busWrite(A_CTRL, 128'h4);
        readLit("clear_from_done", A_STATUS, 128'h0101_0201_0000);

        // Empty-buffer start
        busWrite(A_CTRL, 128'h1);
        readLit("empty_start", A_STATUS, 128'hFF00_0000_0002);

        // Overfill then clear
        for (int i = 0; i < 17; i++) pushSym((i * 3 + 2) % 32);
        readLit("overfill", A_STATUS, 128'hFF00_0000_1006);
        busWrite(A_CTRL, 128'h4);
        readLit("clear_ovf", A_STATUS, 128'hFF00_0000_0000);

        // 16-entry scan aborted in cycle 5, then a full rescan with a dropped push
        for (int i = 0; i < 16; i++) pushSym((i * 5 + 1) % 32);
        busWrite(A_QUERY, 128'd9);
        busWrite(A_CTRL, 128'h1);
        idleN(4);
        busWrite(A_CTRL, 128'h2);
        readLit("abort_partial", A_STATUS, 128'hFF01_0200_1000);
        busWrite(A_CTRL, 128'h1);
        pushSym(5);
        idleN(15);
        busRead(A_STATUS);
        readLit("full_rescan", A_STATUS, 128'h080A_0501_1006);

        // CTRL priority: abort masks clear and start; clear masks start
        busWrite(A_CTRL, 128'h7);
        readLit("prio_abort_wins", A_STATUS, 128'h080A_0501_1006);
        busWrite(A_CTRL, 128'h5);
        readLit("prio_clear_wins", A_STATUS, 128'h080A_0501_0000);

        // Reset in the middle of a scan
        pushSym(1); pushSym(2); pushSym(3);
        busWrite(A_QUERY, 128'd2);
        busWrite(A_CTRL, 128'h1);
        idleN(2);
        applyReset();
        readLit("midscan_reset_status", A_STATUS, 128'hFF00_0000_0000);
        readLit("midscan_reset_query", A_QUERY, 128'h0);
        readLit("unmapped_read", A_UNMAP, 128'h0);
        readLit("ctrl_read_zero", A_CTRL, 128'h0);
        readLit("subj_read_zero", A_SUBJ, 128'h0);
        idleN(3);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter BASE_ADDR, 32'h100, PicoBus base address of the block's register window.
REQ-002 Parameter DEPTH, 16, subject buffer entries (power of two).
REQ-003 Parameter SYM_W, 5, symbol width in bits.
REQ-004 PicoClk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 PicoAddr  in  32  bus address.
REQ-007 PicoDataIn  in  128  write data.
REQ-008 PicoRd  in  1  read strobe, address valid same cycle.
REQ-009 PicoWr  in  1  write strobe, address and data valid same cycle.
REQ-010 PicoDataOut  out  128  registered read data.

Function
REQ-011 The address map SHALL be as follows; all offsets are relative to BASE_ADDR:
- +0x00 CTRL, write only: bit0 start, bit1 abort, bit2 clear.
- +0x10 QUERY: write [SYM_W-1:0]; reads back.
- +0x20 SUBJ: write pushes [SYM_W-1:0] into the buffer.
- +0x30 STATUS: read only.
REQ-012 The FSM SHALL have three states: IDLE=0, SCAN=1, DONE=2.
REQ-013 Start in IDLE or DONE SHALL clear hit/gt/lt counters, set first_hit to all-ones, zero the scan index and enter SCAN; start in SCAN SHALL be ignored.
REQ-014 In SCAN, one buffer entry SHALL be compared with QUERY per cycle, indices 0..count-1 in order; the buffer is not consumed, so a rescan is possible.
REQ-015 The compare SHALL be one registered stage; each result increments exactly one of hit_cnt (equal), gt_cnt (query greater) or lt_cnt (query less).
REQ-016 first_hit SHALL latch the index of the first equal compare of the scan only.
REQ-017 DONE SHALL be entered on the cycle after the last result retires, giving start-write to DONE in count+2 cycles.
REQ-018 DONE SHALL hold until the next start; a STATUS read never changes state.
REQ-019 Start with count=0 SHALL reach DONE on the next cycle with all counters at 0 and first_hit all-ones.
REQ-020 Abort in SCAN SHALL return to IDLE next cycle and discard the in-flight compare; counters keep their partial values.
REQ-021 Clear SHALL zero count in IDLE or DONE (DONE then goes to IDLE); clear in SCAN SHALL be ignored.
REQ-022 A SUBJ push when count==DEPTH or state==SCAN SHALL be dropped and SHALL set the sticky ovf bit.
REQ-023 ovf SHALL be cleared only by clear or by reset.
REQ-024 A QUERY write during SCAN SHALL be ignored.
REQ-025 Simultaneous CTRL bits SHALL take priority abort > clear > start.
REQ-026 The STATUS layout SHALL be:
- [1:0] state, [2] ovf.
- [8+:log2(DEPTH)+1] count.
- [16+:8] hit_cnt, [24+:8] gt_cnt, [32+:8] lt_cnt.
- [40+:8] first_hit.
- All other bits 0.
REQ-027 PicoDataOut SHALL present the addressed register one cycle after PicoRd, and SHALL be 0 for unmapped addresses or when PicoRd=0.

Reset
REQ-028 Reset low SHALL immediately force: state IDLE, count 0, scan index 0, QUERY 0, all counters 0, first_hit all-ones, ovf 0, PicoDataOut 0.
REQ-029 Reset mid-SCAN SHALL abandon the scan with no partial result retained; buffer contents are don't-care.

Structure
REQ-030 A shared package SHALL hold the state enum, the CTRL bit positions, the register offsets and the STATUS field offsets.
REQ-031 The compare stage SHALL be sub-module scan_cmp_unit: a registered equal/greater/less decode with valid, on the same clock and reset.

Verification
REQ-032 Push 3,7,3,9 -> QUERY=3 -> start -> DONE after 6 cycles; hit=2, gt=0, lt=2, first_hit=0.
REQ-033 Start with an empty buffer -> DONE in 1 cycle; STATUS = state 2, count 0, counters 0, first_hit 0xFF.
REQ-034 Push 17 symbols at DEPTH=16 -> count=16, ovf=1; clear -> count=0, ovf=0, state IDLE.
REQ-035 16-entry scan with abort at cycle 5 -> IDLE; partial counters sum to at most 5; restart -> full totals sum to 16.
REQ-036 Reset low mid-SCAN -> all STATUS fields equal reset values; a read at an unmapped address returns 0.
